// File: rtl/main_memory_pkg.sv
// main_memory_pkg: shared constants and request type for the main memory arbiter.
package main_memory_pkg;
  localparam int DATA_W = 32;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA = 1;
  localparam int DEF_MEM_WORDS = 8192;
  localparam int DEF_STARVE_LIMIT = 3;
  typedef struct packed {
    logic req;
    logic we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: fetch, load/store and memory-side signals of the arbiter.
interface main_memory_arbiter_if #(parameter int DATA_W = 32);
  logic if_req;
  logic [DATA_W-1:0] if_addr;
  logic if_gnt;
  logic if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic if_err;
  logic d_req;
  logic d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic d_gnt;
  logic d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic d_err;
  logic [DATA_W-1:0] mem_address;
  logic mem_read_enable;
  logic mem_write_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    input mem_address, mem_read_enable, mem_write_enable, mem_data_in
  );
  modport slave (
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_address, mem_read_enable, mem_write_enable, mem_data_in
  );
endinterface

// File: rtl/main_memory_arb_prio.sv
// main_memory_arb_prio: data-priority grant with a starvation counter protecting fetch.
module main_memory_arb_prio
  import main_memory_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic       d_req,
  output logic [1:0] gnt
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic d_win;
  assign d_win = d_req && !(if_req && starve_cnt == LIM);
  always_comb begin
    gnt = '0;
    gnt[PORT_DATA] = !reset && d_win;
    gnt[PORT_FETCH] = !reset && if_req && !d_win;
  end
  always_ff @(posedge clk)
    if (reset || gnt[PORT_FETCH] || !if_req) starve_cnt <= '0;
    else if (gnt[PORT_DATA] && starve_cnt < LIM) starve_cnt <= starve_cnt + 4'd1;
endmodule

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: shares one word-addressed memory port between fetch and load/store.
module main_memory_arbiter
  import main_memory_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic clk,
  input logic reset,
  main_memory_arbiter_if.slave bus
);
  localparam logic [DATA_W-1:0] ADDR_END = DATA_W'(MEM_WORDS);
  logic [1:0] gnt;
  req_t fetch_r, data_r, sel;
  logic in_range, active, rd_ok;
  main_memory_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk(clk), .reset(reset), .if_req(bus.if_req), .d_req(bus.d_req), .gnt(gnt)
  );
  assign fetch_r = '{req: bus.if_req, we: 1'b0, addr: bus.if_addr, wdata: '0};
  assign data_r = '{req: bus.d_req, we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
  assign sel = gnt[PORT_DATA] ? data_r : fetch_r;
  assign in_range = sel.addr < ADDR_END;
  assign active = |gnt && sel.req && in_range;
  assign rd_ok = active && !sel.we;
  assign bus.if_gnt = gnt[PORT_FETCH];
  assign bus.d_gnt = gnt[PORT_DATA];
  assign bus.mem_address = active ? sel.addr : '0;
  assign bus.mem_read_enable = rd_ok;
  assign bus.mem_write_enable = active && sel.we;
  assign bus.mem_data_in = (active && sel.we) ? sel.wdata : '0;
  // Rdata is zeroed whenever the response is not an in-range read.
  always_ff @(posedge clk)
    if (reset) begin
      bus.if_rvalid <= 1'b0;
      bus.if_err <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_err <= 1'b0;
      bus.d_rdata <= '0;
    end else begin
      bus.if_rvalid <= gnt[PORT_FETCH];
      bus.if_err <= gnt[PORT_FETCH] && !in_range;
      bus.if_rdata <= (gnt[PORT_FETCH] && rd_ok) ? bus.mem_data_out : '0;
      bus.d_rvalid <= gnt[PORT_DATA];
      bus.d_err <= gnt[PORT_DATA] && !in_range;
      bus.d_rdata <= (gnt[PORT_DATA] && rd_ok) ? bus.mem_data_out : '0;
    end
endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter: directed checks of arbitration, memory drive and responses.
module tb_main_memory_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vecs = 0;
  int errs = 0;
  logic [31:0] mem [0:8191];
  main_memory_arbiter_if #(.DATA_W(32)) bus ();
  main_memory_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_data_out = mem[bus.mem_address[12:0]];
  always @(posedge clk)
    if (bus.mem_write_enable && !bus.mem_read_enable) mem[bus.mem_address[12:0]] <= bus.mem_data_in;

  task automatic idle();
    bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
    bus.if_addr = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 7; bus.d_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vecs++; if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin errs++; $display("FAIL rst_gnt cyc%0d: got %b want 00", i, {bus.if_gnt, bus.d_gnt}); end
      vecs++; if ({bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_in} !== '0) begin errs++; $display("FAIL rst_mem cyc%0d: re=%b we=%b a=%h d=%h want all 0", i, bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_in); end
      vecs++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.if_rdata, bus.d_rdata} !== '0) begin errs++; $display("FAIL rst_resp cyc%0d: responses not all 0", i); end
    end
    vecs++; if (mem[7] !== 32'hA000_0007) begin errs++; $display("FAIL rst_nowrite: got %h want a0000007", mem[7]); end
    @(negedge clk);
    reset = 0; bus.d_we = 0; #1;
    vecs++; if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin errs++; $display("FAIL rel_gnt: got %b want 01", {bus.if_gnt, bus.d_gnt}); end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_store_load();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5; bus.d_wdata = 32'hDEAD_BEEF; #1;
    vecs++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL st_gnt: got %b want 1", bus.d_gnt); end
    vecs++; if ({bus.mem_write_enable, bus.mem_read_enable} !== 2'b10) begin errs++; $display("FAIL st_en: we/re got %b want 10", {bus.mem_write_enable, bus.mem_read_enable}); end
    vecs++; if ({bus.mem_address, bus.mem_data_in} !== {32'd5, 32'hDEAD_BEEF}) begin errs++; $display("FAIL st_port: a=%h d=%h want 5 deadbeef", bus.mem_address, bus.mem_data_in); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h0}) begin errs++; $display("FAIL st_resp: v=%b e=%b d=%h want 1 0 0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    bus.d_we = 0; #1;
    vecs++; if ({bus.d_gnt, bus.mem_write_enable, bus.mem_read_enable} !== 3'b101) begin errs++; $display("FAIL ld_en: gnt/we/re got %b want 101", {bus.d_gnt, bus.mem_write_enable, bus.mem_read_enable}); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errs++; $display("FAIL ld_resp: v=%b e=%b d=%h want 1 0 deadbeef", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    idle();
    @(negedge clk);
    vecs++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL ld_pulse: rvalid got %b want 0", bus.d_rvalid); end
  endtask

  task automatic test_fetch();
    bus.if_req = 1; bus.if_addr = 5; #1;
    vecs++; if ({bus.if_gnt, bus.d_gnt, bus.mem_read_enable} !== 3'b101) begin errs++; $display("FAIL f_gnt: ifg/dg/re got %b want 101", {bus.if_gnt, bus.d_gnt, bus.mem_read_enable}); end
    @(negedge clk);
    vecs++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errs++; $display("FAIL f_resp: v=%b e=%b d=%h want 1 0 deadbeef", bus.if_rvalid, bus.if_err, bus.if_rdata); end
    vecs++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL f_drv: got %b want 0", bus.d_rvalid); end
    bus.if_addr = 8191; #1;
    @(negedge clk);
    vecs++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b10, 32'hA000_1FFF}) begin errs++; $display("FAIL f_top: v=%b e=%b d=%h want 1 0 a0001fff", bus.if_rvalid, bus.if_err, bus.if_rdata); end
    bus.if_addr = 8192; #1;
    vecs++; if ({bus.if_gnt, bus.mem_read_enable, bus.mem_address} !== {2'b10, 32'h0}) begin errs++; $display("FAIL f_oor_port: g=%b re=%b a=%h want 1 0 0", bus.if_gnt, bus.mem_read_enable, bus.mem_address); end
    @(negedge clk);
    vecs++; if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b11, 32'h0}) begin errs++; $display("FAIL f_oor_resp: v=%b e=%b d=%h want 1 1 0", bus.if_rvalid, bus.if_err, bus.if_rdata); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] want;
    bus.if_req = 1; bus.if_addr = 2; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = (k % 4 == 3) ? 2'b10 : 2'b01;
      vecs++; if ({bus.if_gnt, bus.d_gnt} !== want) begin errs++; $display("FAIL cont_gnt cyc%0d: got %b want %b", k, {bus.if_gnt, bus.d_gnt}, want); end
      vecs++; if (dut.u_prio.starve_cnt !== 4'(k % 4)) begin errs++; $display("FAIL cont_cnt cyc%0d: got %0d want %0d", k, dut.u_prio.starve_cnt, k % 4); end
      @(negedge clk);
      vecs++; if ({bus.if_rvalid, bus.d_rvalid} !== want) begin errs++; $display("FAIL cont_resp cyc%0d: got %b want %b", k, {bus.if_rvalid, bus.d_rvalid}, want); end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8192; #1;
    vecs++; if ({bus.d_gnt, bus.mem_read_enable, bus.mem_write_enable, bus.mem_address} !== {3'b100, 32'h0}) begin errs++; $display("FAIL oor_ld_port: g=%b re=%b we=%b a=%h want 1 0 0 0", bus.d_gnt, bus.mem_read_enable, bus.mem_write_enable, bus.mem_address); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin errs++; $display("FAIL oor_ld_resp: v=%b e=%b d=%h want 1 1 0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    bus.d_we = 1; bus.d_addr = 32'hFFFF_FFFF; bus.d_wdata = 32'h1234_5678; #1;
    vecs++; if ({bus.mem_read_enable, bus.mem_write_enable, bus.mem_address} !== {2'b00, 32'h0}) begin errs++; $display("FAIL oor_st_port: re=%b we=%b a=%h want 0 0 0", bus.mem_read_enable, bus.mem_write_enable, bus.mem_address); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin errs++; $display("FAIL oor_st_resp: v=%b e=%b d=%h want 1 1 0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    vecs++; if ({mem[0], mem[8191]} !== {32'hA000_0000, 32'hA000_1FFF}) begin errs++; $display("FAIL oor_mem: m0=%h m8191=%h want a0000000 a0001fff", mem[0], mem[8191]); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 3;
    @(negedge clk); #1;
    vecs++; if ({bus.d_gnt, dut.u_prio.starve_cnt} !== {1'b1, 4'd1}) begin errs++; $display("FAIL rm_pre: gnt=%b cnt=%0d want 1 1", bus.d_gnt, dut.u_prio.starve_cnt); end
    reset = 1; #1;
    vecs++; if ({bus.if_gnt, bus.d_gnt, bus.mem_read_enable} !== 3'b000) begin errs++; $display("FAIL rm_gnt: got %b want 000", {bus.if_gnt, bus.d_gnt, bus.mem_read_enable}); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.if_rvalid} !== 2'b00) begin errs++; $display("FAIL rm_drop: rvalid got %b want 00", {bus.d_rvalid, bus.if_rvalid}); end
    vecs++; if (dut.u_prio.starve_cnt !== 4'd0) begin errs++; $display("FAIL rm_cnt: got %0d want 0", dut.u_prio.starve_cnt); end
    bus.if_req = 0; bus.d_addr = 5;
    reset = 0; #1;
    vecs++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL rm_regnt: got %b want 1", bus.d_gnt); end
    @(negedge clk);
    vecs++; if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errs++; $display("FAIL rm_ld: v=%b e=%b d=%h want 1 0 deadbeef", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    idle();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA000_0000 + 32'(i);
    idle();
    test_reset();
    test_store_load();
    test_fetch();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Two-port arbiter and sequencer for the unified main memory: shares its single word-addressed port between instruction fetch and load/store. Sits between the fetch/memory pipeline stages and the memory. Data accesses take priority, and a starvation counter bounds how long fetch can be locked out. Read data and write acknowledges return one cycle after grant; out-of-range addresses are flagged instead of touching memory.

## Interface
- DATA_W, 32, data and address width
- MEM_WORDS, 8192, number of valid word addresses; valid range is 0..MEM_WORDS-1
- STARVE_LIMIT, 3, max consecutive data grants while fetch waits; legal range 1..15
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock, no other reset
- ifReq  in  1  fetch read request, held until ifGnt
- ifAddr  in  DATA_W  fetch word address
- ifGnt  out  1  fetch request accepted this cycle (combinational)
- ifRvalid  out  1  fetch response valid (registered)
- ifRdata  out  DATA_W  fetch read data (registered)
- ifErr  out  1  fetch address out of range, qualified by ifRvalid
- dReq  in  1  load/store request, held until dGnt
- dWe  in  1  1 = store, 0 = load
- dAddr  in  DATA_W  data word address
- dWdata  in  DATA_W  store data
- dGnt  out  1  data request accepted this cycle (combinational)
- dRvalid  out  1  data response valid: load data or store acknowledge (registered)
- dRdata  out  DATA_W  load data; 0 for stores
- dErr  out  1  data address out of range, qualified by dRvalid
- memAddress  out  DATA_W  to memory address
- memReadEnable  out  1  to memory readEnable
- memWriteEnable  out  1  to memory writeEnable
- memDataIn  out  DATA_W  to memory dataIn
- memDataOut  in  DATA_W  from memory dataOut; combinational read of memAddress

## Operation
- Grant rule, evaluated every cycle while reset is low:
  - If only one requester is active, that requester is granted.
  - If both are active and starveCnt < STARVE_LIMIT, data is granted.
  - If both are active and starveCnt == STARVE_LIMIT, fetch is granted.
- At most one grant per cycle. Grants are 0 while reset is high.
- starveCnt (4 bits) is updated each cycle:
  - It increments when dGnt is high and ifReq is high.
  - It clears when ifGnt is high or ifReq is low.
  - It never exceeds STARVE_LIMIT.
- Memory port drive in the grant cycle:
  - memAddress is the granted address.
  - A granted load or fetch drives memReadEnable=1, memWriteEnable=0.
  - A granted store drives memWriteEnable=1, memReadEnable=0, memDataIn=dWdata. The memory only writes when readEnable is low.
  - With no grant, or an out-of-range address (addr >= MEM_WORDS, unsigned compare on the full width), both enables are 0 and memAddress=0. No memory access occurs.
- Response, registered at the end of the grant cycle:
  - The granted port's Rvalid goes high for exactly one cycle.
  - Rdata is memDataOut for an in-range read; 0 for stores and out-of-range accesses.
  - Err is 1 only for out-of-range accesses.
- Requesters must not change Addr, dWe or dWdata while Req is high and Gnt is low. The arbiter samples them only in the grant cycle.
- Responses have no backpressure; the requester must accept Rvalid unconditionally.

## Timing
- Reset values: ifRvalid, dRvalid, ifErr, dErr = 0; ifRdata, dRdata = 0; starveCnt = 0. All mem outputs are 0 and both grants are 0 while reset is high.
- Latency: grant in cycle N, response in cycle N+1. A store is visible to a read granted in N+1.
- Throughput: one access per cycle. Back-to-back grants to the same port give consecutive Rvalid pulses.
- Simultaneous requests: data wins until the starvation limit. With STARVE_LIMIT=3, fetch is granted no later than the 4th cycle of contention.
- Reset asserted mid-operation: any response due in the next cycle is dropped (Rvalid=0). A grant coincident with reset does not occur. No memory write occurs in a cycle with reset high.
- Reset released: the first grant can happen in the same cycle reset is low.

## Structure
- Package main_memory_pkg holds:
  - port index constants PORT_FETCH=0 and PORT_DATA=1
  - default MEM_WORDS and STARVE_LIMIT
  - a request struct {req, we, addr, wdata} used for both ports (fetch ties we=0)
- One sub-module, main_memory_arb_prio: the grant logic plus starveCnt, returning a one-hot grant.
- Memory port muxing, the range check and the response registers stay in the top level.

## Test plan
- Reset held 3 cycles with both requests high -> no grants, all outputs 0. After release, dGnt=1 in the first cycle.
- Store dAddr=5, dWdata=0xDEADBEEF, then load dAddr=5 in the next cycle:
  - store cycle: memWriteEnable=1 for one cycle
  - one cycle later: dRvalid=1, dRdata=0, dErr=0
  - load response: dRdata=0xDEADBEEF
- Fetch ifAddr=5 alone -> ifGnt=1 same cycle; next cycle ifRvalid=1, ifRdata equals memory word 5.
- ifReq and dReq held high continuously -> grant pattern data, data, data, fetch, repeating; starveCnt never exceeds 3.
- Out-of-range load dAddr=8192 and store dAddr=0xFFFFFFFF -> both enables stay 0 and memory is unchanged; responses have dErr=1, dRdata=0.
- Reset asserted in the cycle after a load grant -> dRvalid stays 0. After release, starveCnt restarts from 0 and the next load behaves normally.
